// File: rtl/l1_inst_fill_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : l1_inst_fill_responder_pkg
// Desc     : Shared processor header for the L1 instruction fill responder:
//            tag layout, MMU mode encodings and bus widths.
// Revision : 1.0 - initial release
// ============================================================================
package l1_inst_fill_responder_pkg;

  // Tag carried per accepted request through the in-order tag FIFO
  localparam int TAG_W = 1;

  // MMU mode field; physical mode bypasses translation checks
  localparam int         MMUMOD_W    = 2;
  localparam logic [1:0] MMUMOD_PHYS = 2'h0;

  // Bus widths
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 64;
  localparam int FLAGS_W     = 14;
  localparam int OUT_FLAGS_W = 2 * FLAGS_W;

  typedef struct packed {
    logic fault;
  } inst_tag_t;

  // A translated access at or beyond the limit cannot be fetched
  function automatic logic page_fault(input logic [MMUMOD_W-1:0] mode,
                                      input logic [ADDR_W-1:0]   addr,
                                      input logic [ADDR_W-1:0]   limit);
    return (mode != MMUMOD_PHYS) && (addr >= limit);
  endfunction

endpackage
`default_nettype wire

// File: rtl/l1_inst_fill_responder_resp_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : resp_sync_fifo
// Desc     : Single-clock FIFO with first-word-fall-through head, synchronous
//            clear, full/empty flags and occupancy count. DEPTH must be a
//            power of two so pointers wrap naturally.
// Revision : 1.0 - initial release
// ============================================================================
module resp_sync_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push && !clr) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/l1_inst_fill_responder.sv
`default_nettype none
// ============================================================================
// Module   : l1_inst_fill_responder
// Desc     : Accepts 64-bit instruction fetch requests, forwards non-faulting
//            ones to the memory backend and returns one response beat per
//            request in acceptance order. Faulting requests (translated mode,
//            address >= limit) are answered locally with a page-fault beat.
//            Optional feature macro: INST_RESP_PAGECHECK_EN enables the page
//            limit check; without it no request faults.
// Revision : 1.0 - initial release
// ============================================================================
module l1_inst_fill_responder
  import l1_inst_fill_responder_pkg::*;
#(
  parameter int P_DEPTH = 8
) (
  input  logic                   iCLOCK,
  input  logic                   inRESET,
  input  logic                   iREMOVE,
  input  logic                   iINST_REQ,
  input  logic [MMUMOD_W-1:0]    iINST_MMUMOD,
  input  logic [ADDR_W-1:0]      iINST_ADDR,
  output logic                   oINST_LOCK,
  output logic                   oINST_VALID,
  output logic                   oINST_PAGEFAULT,
  output logic [DATA_W-1:0]      oINST_DATA,
  output logic [OUT_FLAGS_W-1:0] oINST_MMU_FLAGS,
  input  logic                   iINST_BUSY,
  input  logic [ADDR_W-1:0]      iMMU_LIMIT,
  input  logic [FLAGS_W-1:0]     iMMU_FLAGS,
  output logic                   oMEM_REQ,
  output logic [ADDR_W-1:0]      oMEM_ADDR,
  input  logic                   iMEM_LOCK,
  input  logic                   iMEM_VALID,
  input  logic [DATA_W-1:0]      iMEM_DATA
);

  localparam int CNT_W = $clog2(P_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  // --------------------------------------------------------------------------
  // Request side
  // --------------------------------------------------------------------------
  logic             lock;
  logic             accept;
  logic             req_fault;
  logic             mem_issue;
  logic [SUM_W-1:0] committed;
  logic             capacity_hit;

  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] discard;

  // Tag FIFO
  inst_tag_t        tag_in;
  inst_tag_t        tag_head;
  logic             tag_full;
  logic             tag_empty;
  logic [CNT_W-1:0] tag_count;
  logic             tag_pop;

  // Data FIFO
  logic [DATA_W-1:0] data_head;
  logic              data_full;
  logic              data_empty;
  logic [CNT_W-1:0]  data_count;
  logic              data_push;
  logic              data_pop;

  // Output register
  logic                   out_valid;
  logic                   out_fault;
  logic [DATA_W-1:0]      out_data;
  logic [OUT_FLAGS_W-1:0] out_flags;
  logic                   consume;
  logic                   out_free;
  logic                   emit;

`ifdef INST_RESP_PAGECHECK_EN
  assign req_fault       = page_fault(iINST_MMUMOD, iINST_ADDR, iMMU_LIMIT);
  assign oINST_PAGEFAULT = out_fault;
`else
  logic unused_cfg;
  assign req_fault       = 1'b0;
  assign oINST_PAGEFAULT = 1'b0;
  assign unused_cfg      = ^{iINST_MMUMOD, iMMU_LIMIT, out_fault};
`endif

  // Every queued beat plus every beat still in flight must fit in the data FIFO
  assign committed    = {1'b0, data_count} + {1'b0, outstanding};
  assign capacity_hit = (committed >= SUM_W'(P_DEPTH));

  // Locked while flushing and until the flushed in-flight beats have drained
  assign lock       = tag_full || iMEM_LOCK || capacity_hit || iREMOVE || (discard != '0);
  assign oINST_LOCK = lock;

  assign accept    = iINST_REQ && !lock && inRESET;
  assign oMEM_REQ  = accept && !req_fault;
  assign oMEM_ADDR = iINST_ADDR;
  assign mem_issue = oMEM_REQ && !iMEM_LOCK;

  assign tag_in.fault = req_fault;

  // Backend beats belonging to flushed requests never enter the data FIFO
  assign data_push = iMEM_VALID && !iREMOVE && (discard == '0);

  // --------------------------------------------------------------------------
  // Response side
  // --------------------------------------------------------------------------
  assign consume  = out_valid && !iINST_BUSY;
  assign out_free = !out_valid || consume;
  assign emit     = !tag_empty && (tag_head.fault || !data_empty) && out_free && !iREMOVE;
  assign tag_pop  = emit;
  assign data_pop = emit && !tag_head.fault;

  assign oINST_VALID     = out_valid;
  assign oINST_DATA      = out_data;
  assign oINST_MMU_FLAGS = out_flags;

  logic unused_status;
  assign unused_status = ^{tag_count, data_full};

  resp_sync_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (P_DEPTH)
  ) u_tag_fifo (
    .clk       (iCLOCK),
    .rst_n     (inRESET),
    .clr       (iREMOVE),
    .push      (accept),
    .push_data (tag_in),
    .pop       (tag_pop),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  resp_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (P_DEPTH)
  ) u_data_fifo (
    .clk       (iCLOCK),
    .rst_n     (inRESET),
    .clr       (iREMOVE),
    .push      (data_push),
    .push_data (iMEM_DATA),
    .pop       (data_pop),
    .head      (data_head),
    .full      (data_full),
    .empty     (data_empty),
    .count     (data_count)
  );

  // Track backend requests in flight and how many flushed beats remain to drop
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      outstanding <= '0;
      discard     <= '0;
    end else begin
      case ({mem_issue, iMEM_VALID && (outstanding != '0)})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase

      if (iREMOVE) begin
        // A beat returning in the flush cycle itself is already dropped
        discard <= (iMEM_VALID && (outstanding != '0)) ? outstanding - 1'b1 : outstanding;
      end else if (iMEM_VALID && (discard != '0)) begin
        discard <= discard - 1'b1;
      end
    end
  end

  // Output beat register: loads on emit, holds under backpressure
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      out_valid <= 1'b0;
      out_fault <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
    end else if (iREMOVE) begin
      out_valid <= 1'b0;
      out_fault <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_fault <= tag_head.fault;
      out_data  <= tag_head.fault ? '0 : data_head;
      out_flags <= tag_head.fault ? '0 : {iMMU_FLAGS, iMMU_FLAGS};
    end else if (consume) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_l1_inst_fill_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_l1_inst_fill_responder
// Desc     : Directed self-checking bench for l1_inst_fill_responder with a
//            fixed-latency backend model and an in-order beat scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l1_inst_fill_responder;

  localparam int DEPTH = 8;
`ifdef INST_RESP_PAGECHECK_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif
  localparam logic [13:0] FLAGS = 14'h2A5;
  localparam logic [31:0] LIMIT = 32'h0000_2000;

  logic        iCLOCK       = 1'b0;
  logic        inRESET      = 1'b0;
  logic        iREMOVE      = 1'b0;
  logic        iINST_REQ    = 1'b0;
  logic [1:0]  iINST_MMUMOD = 2'h0;
  logic [31:0] iINST_ADDR   = 32'h0;
  logic        iINST_BUSY   = 1'b0;
  logic [31:0] iMMU_LIMIT   = LIMIT;
  logic [13:0] iMMU_FLAGS   = FLAGS;
  logic        iMEM_LOCK    = 1'b0;
  logic        iMEM_VALID   = 1'b0;
  logic [63:0] iMEM_DATA    = 64'h0;
  logic        oINST_LOCK;
  logic        oINST_VALID;
  logic        oINST_PAGEFAULT;
  logic [63:0] oINST_DATA;
  logic [27:0] oINST_MMU_FLAGS;
  logic        oMEM_REQ;
  logic [31:0] oMEM_ADDR;

  l1_inst_fill_responder #(.P_DEPTH(DEPTH)) dut (
    .iCLOCK          (iCLOCK),
    .inRESET         (inRESET),
    .iREMOVE         (iREMOVE),
    .iINST_REQ       (iINST_REQ),
    .iINST_MMUMOD    (iINST_MMUMOD),
    .iINST_ADDR      (iINST_ADDR),
    .oINST_LOCK      (oINST_LOCK),
    .oINST_VALID     (oINST_VALID),
    .oINST_PAGEFAULT (oINST_PAGEFAULT),
    .oINST_DATA      (oINST_DATA),
    .oINST_MMU_FLAGS (oINST_MMU_FLAGS),
    .iINST_BUSY      (iINST_BUSY),
    .iMMU_LIMIT      (iMMU_LIMIT),
    .iMMU_FLAGS      (iMMU_FLAGS),
    .oMEM_REQ        (oMEM_REQ),
    .oMEM_ADDR       (oMEM_ADDR),
    .iMEM_LOCK       (iMEM_LOCK),
    .iMEM_VALID      (iMEM_VALID),
    .iMEM_DATA       (iMEM_DATA)
  );

  always #5 iCLOCK = ~iCLOCK;

  typedef struct packed {
    logic        pf;
    logic [63:0] data;
    logic [27:0] flags;
  } beat_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  beat_t exp_q[$];
  mreq_t be_q[$];
  int    n_checks     = 0;
  int    n_fail       = 0;
  int    n_beats      = 0;
  int    cyc          = 0;
  int    be_delay     = 3;
  int    ret_cnt      = 0;
  logic  last_mem_req = 1'b0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic beat_t model_beat(input logic [1:0] mode, input logic [31:0] addr,
                                       input logic [31:0] limit);
    beat_t b;
    if (FAULT_EN && (mode != 2'h0) && (addr >= limit)) begin
      b.pf = 1'b1; b.data = 64'h0; b.flags = 28'h0;
    end else begin
      b.pf = 1'b0; b.data = {~addr, addr}; b.flags = {FLAGS, FLAGS};
    end
    return b;
  endfunction

  // Backend: returns {~addr, addr} for each request, in order, after be_delay cycles
  initial begin
    forever begin
      @(posedge iCLOCK);
      cyc++;
      #1;
      if (inRESET && be_q.size() > 0 && be_q[0].due <= cyc) begin
        iMEM_VALID = 1'b1;
        iMEM_DATA  = {~be_q[0].addr, be_q[0].addr};
        void'(be_q.pop_front());
        ret_cnt++;
      end else begin
        iMEM_VALID = 1'b0;
        iMEM_DATA  = 64'h0;
      end
    end
  end

  // Monitor: record backend requests, check held beats stay stable, score consumed beats
  logic        held_v = 1'b0;
  logic [93:0] held   = '0;
  initial begin
    beat_t e;
    forever begin
      @(negedge iCLOCK);
      if (oMEM_REQ && !iMEM_LOCK) be_q.push_back('{addr: oMEM_ADDR, due: cyc + be_delay});
      if (held_v)
        check_eq("hold_stable", {oINST_VALID, oINST_PAGEFAULT, oINST_DATA, oINST_MMU_FLAGS}, held);
      held_v = oINST_VALID && iINST_BUSY;
      held   = {oINST_VALID, oINST_PAGEFAULT, oINST_DATA, oINST_MMU_FLAGS};
      if (oINST_VALID && !iINST_BUSY) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_beat", {oINST_PAGEFAULT, oINST_DATA}, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("beat", {oINST_PAGEFAULT, oINST_DATA, oINST_MMU_FLAGS}, e);
          n_beats++;
        end
      end
    end
  end

  // Drive one request and wait (bounded) until it is accepted; returns at posedge+1
  task automatic issue(input logic [1:0] mode, input logic [31:0] addr);
    bit done = 0;
    int tries = 0;
    iINST_REQ = 1'b1; iINST_MMUMOD = mode; iINST_ADDR = addr;
    while (!done && tries < 64) begin
      @(negedge iCLOCK);
      if (!oINST_LOCK) begin
        done = 1;
        last_mem_req = oMEM_REQ;
        exp_q.push_back(model_beat(mode, addr, iMMU_LIMIT));
      end
      @(posedge iCLOCK); #1;
      tries++;
    end
    if (!done) check_eq("issue_timeout", 0, 1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge iCLOCK);
      if (exp_q.size() == 0 && be_q.size() == 0 && !oINST_VALID) break;
    end
    check_eq(tag, exp_q.size(), 0);
    @(posedge iCLOCK); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          b0;
    int          r0;
    int          n_acc;
    logic [31:0] addr;

    // Reset state
    repeat (3) @(posedge iCLOCK);
    @(negedge iCLOCK);
    check_eq("rst_valid", oINST_VALID, 0);
    check_eq("rst_pf", oINST_PAGEFAULT, 0);
    check_eq("rst_data", oINST_DATA, 0);
    check_eq("rst_flags", oINST_MMU_FLAGS, 0);
    check_eq("rst_memreq", oMEM_REQ, 0);
    @(posedge iCLOCK); #1;
    inRESET = 1'b1;
    @(negedge iCLOCK);
    check_eq("rst_lock", oINST_LOCK, 0);
    @(posedge iCLOCK); #1;

    // Eight physical-mode requests, returned in order
    b0 = n_beats;
    for (int i = 0; i < 8; i++) issue(2'h0, 32'h1000 + 32'(i * 8));
    iINST_REQ = 1'b0;
    drain("t1_drain");
    check_eq("t1_count", n_beats - b0, 8);

    // Translated request at the limit: faults locally one cycle after its tag lands
    issue(2'h1, 32'h2000);
    iINST_REQ = 1'b0;
    check_eq("t2_memreq", last_mem_req, !FAULT_EN);
    @(negedge iCLOCK);
    check_eq("t2_lat0", oINST_VALID, 0);
    @(negedge iCLOCK);
    check_eq("t2_lat1", oINST_VALID, FAULT_EN);
    check_eq("t2_pf", oINST_PAGEFAULT, FAULT_EN);
    @(posedge iCLOCK); #1;
    drain("t2_drain");

    // Interleaved data / fault / data
    b0 = n_beats;
    issue(2'h1, 32'h1000);
    issue(2'h1, 32'h3000);
    check_eq("t3_memreq", last_mem_req, !FAULT_EN);
    issue(2'h1, 32'h1008);
    iINST_REQ = 1'b0;
    drain("t3_drain");
    check_eq("t3_count", n_beats - b0, 3);

    // Backpressure: fill to capacity while the requester is busy
    b0 = n_beats;
    iINST_BUSY = 1'b1;
    addr = 32'h4000;
    n_acc = 0;
    for (int c = 0; c < 20; c++) begin
      iINST_REQ = 1'b1; iINST_MMUMOD = 2'h0; iINST_ADDR = addr;
      @(negedge iCLOCK);
      if (!oINST_LOCK) begin
        exp_q.push_back(model_beat(2'h0, addr, iMMU_LIMIT));
        n_acc++;
        addr += 32'h8;
      end
      @(posedge iCLOCK); #1;
    end
    iINST_REQ = 1'b0;
    @(negedge iCLOCK);
    check_eq("t4_lock_full", oINST_LOCK, 1);
    check_eq("t4_accepted", n_acc, DEPTH + 1);
    check_eq("t4_held_valid", oINST_VALID, 1);
    repeat (5) @(posedge iCLOCK);
    #1;
    iINST_BUSY = 1'b0;
    drain("t4_drain");
    check_eq("t4_count", n_beats - b0, DEPTH + 1);

    // Flush with three requests in flight
    be_delay = 6;
    b0 = n_beats;
    r0 = ret_cnt;
    for (int i = 0; i < 3; i++) issue(2'h0, 32'h5000 + 32'(i * 8));
    iINST_REQ = 1'b0;
    iREMOVE = 1'b1;
    @(negedge iCLOCK);
    check_eq("t5_lock_remove", oINST_LOCK, 1);
    @(posedge iCLOCK); #1;
    iREMOVE = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 50; i++) begin
      @(negedge iCLOCK);
      if (ret_cnt - r0 >= 3) break;
    end
    check_eq("t5_returns", ret_cnt - r0, 3);
    check_eq("t5_lock_last", oINST_LOCK, 1);
    @(negedge iCLOCK);
    check_eq("t5_lock_free", oINST_LOCK, 0);
    check_eq("t5_no_beats", n_beats - b0, 0);
    check_eq("t5_valid", oINST_VALID, 0);
    be_delay = 3;
    @(posedge iCLOCK); #1;

    // Reset in the middle of a burst
    for (int i = 0; i < 4; i++) issue(2'h0, 32'h6000 + 32'(i * 8));
    iINST_ADDR = 32'h6020;
    @(negedge iCLOCK);
    #2;
    inRESET = 1'b0;
    #1;
    check_eq("t6_valid", oINST_VALID, 0);
    check_eq("t6_pf", oINST_PAGEFAULT, 0);
    check_eq("t6_data", oINST_DATA, 0);
    check_eq("t6_flags", oINST_MMU_FLAGS, 0);
    check_eq("t6_memreq", oMEM_REQ, 0);
    iINST_REQ = 1'b0;
    exp_q.delete();
    be_q.delete();
    @(posedge iCLOCK); #1;
    @(posedge iCLOCK); #1;
    inRESET = 1'b1;
    @(negedge iCLOCK);
    check_eq("t6_lock", oINST_LOCK, 0);
    @(posedge iCLOCK); #1;
    b0 = n_beats;
    issue(2'h0, 32'h7000);
    issue(2'h0, 32'h7008);
    iINST_REQ = 1'b0;
    drain("t6_drain");
    check_eq("t6_count", n_beats - b0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/l1_inst_fill_responder.md
L1_INST_FILL_RESPONDER -- requirements
Module: l1_inst_fill_responder

Interface
REQ-001 SHALL have parameter P_DEPTH, default 8, meaning outstanding-request capacity (power of 2, min 2).
REQ-002 SHALL have port iCLOCK  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port inRESET  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port iREMOVE  in  1  flush: discard all queued and in-flight requests.
REQ-005 SHALL have port iINST_REQ  in  1, iINST_MMUMOD  in  2, iINST_ADDR  in  32: request from the instruction cache, 64-bit-aligned.
REQ-006 SHALL have port oINST_LOCK  out  1  request not accepted this cycle.
REQ-007 SHALL have port oINST_VALID  out  1, oINST_PAGEFAULT  out  1, oINST_DATA  out  64, oINST_MMU_FLAGS  out  28: response beat.
REQ-008 SHALL have port iINST_BUSY  in  1  requester cannot take a beat.
REQ-009 SHALL have port iMMU_LIMIT  in  32, iMMU_FLAGS  in  14: translation limit and per-word flags.
REQ-010 SHALL have port oMEM_REQ  out  1, oMEM_ADDR  out  32, iMEM_LOCK  in  1: backend request.
REQ-011 SHALL have port iMEM_VALID  in  1, iMEM_DATA  in  64: backend in-order return, no backpressure.

Function
REQ-012 SHALL accept a request when iINST_REQ && !oINST_LOCK; oINST_LOCK = tag FIFO full || iMEM_LOCK || data FIFO count + outstanding >= P_DEPTH.
REQ-013 SHALL classify each accepted request as faulting when iINST_MMUMOD != 0 and iINST_ADDR >= iMMU_LIMIT (see REQ-026).
REQ-014 SHALL push one tag {fault} per accepted request into an in-order tag FIFO.
REQ-015 SHALL drive oMEM_REQ = accept && !fault, oMEM_ADDR = iINST_ADDR, same cycle (combinational); faulting requests never reach the backend.
REQ-016 SHALL push iMEM_DATA into a data FIFO on every iMEM_VALID not discarded per REQ-021.
REQ-017 SHALL emit a beat, registered, one cycle after: tag FIFO non-empty && (head tag faulting || data FIFO non-empty) && output register free or being consumed.
REQ-018 SHALL for a non-fault beat pop tag and data, drive oINST_PAGEFAULT=0, oINST_DATA=data, oINST_MMU_FLAGS={iMMU_FLAGS,iMMU_FLAGS}.
REQ-019 SHALL for a fault beat pop tag only, drive oINST_PAGEFAULT=1, oINST_DATA=0, oINST_MMU_FLAGS=0.
REQ-020 SHALL hold oINST_VALID and all beat fields stable while iINST_BUSY=1; beat consumed on oINST_VALID && !iINST_BUSY.
REQ-021 SHALL maintain an outstanding counter (+1 on oMEM_REQ && !iMEM_LOCK, -1 on iMEM_VALID, simultaneous = no change); on iREMOVE copy it into a discard counter, clear FIFOs and output register, and drop the next discard-count iMEM_VALID beats.
REQ-022 SHALL hold oINST_LOCK=1 during the iREMOVE cycle and while discard counter != 0.
REQ-023 SHALL treat simultaneous push and pop on a full FIFO as legal (count unchanged); pointers wrap modulo P_DEPTH.
REQ-024 SHALL never drop or reorder beats; response order equals acceptance order.

Reset
REQ-025 SHALL on inRESET=0 clear FIFOs, counters, output register; oINST_VALID=0, oINST_PAGEFAULT=0, oINST_DATA=0, oINST_MMU_FLAGS=0, oMEM_REQ=0; oINST_LOCK=0 on the first cycle after reset with empty state; backend beats arriving after reset are outside scope.

Configuration
REQ-026 SHALL with INST_RESP_PAGECHECK_EN defined apply REQ-013; without it no request faults, oINST_PAGEFAULT is constant 0, iMMU_LIMIT ignored.

Structure
REQ-027 SHALL place tag-width and MMU mode constants (physical mode = 2'h0) in the shared processor header.
REQ-028 SHALL instantiate sub-module resp_sync_fifo (parameterised width/depth, full/empty/count) for both tag and data FIFOs.

Verification
REQ-029 SHALL cover: 8 requests mode 0 addr 0x1000..0x1038, backend returns after 3 cycles -> 8 beats in order, PAGEFAULT=0, data matches.
REQ-030 SHALL cover: mode 1, iMMU_LIMIT=0x2000, addr 0x2000 -> no oMEM_REQ, one beat PAGEFAULT=1 one cycle after acceptance.
REQ-031 SHALL cover: interleaved fault/non-fault (0x1000, 0x3000 fault, 0x1008) -> beats in order data, fault, data.
REQ-032 SHALL cover: iINST_BUSY=1 for 5 cycles with P_DEPTH returns pending -> beat held stable, oINST_LOCK=1 at capacity, no loss.
REQ-033 SHALL cover: iREMOVE with 3 outstanding -> next 3 iMEM_VALID discarded, no beats emitted, LOCK deasserts after 3rd.
REQ-034 SHALL cover: inRESET asserted mid-burst -> all outputs 0 asynchronously, clean restart.
